// File: rtl/reg16_ser_pkg.sv
// rtl/reg16_ser_pkg.sv - shared types, constants and emission order for the reg16_ser10 unloader
package reg16_ser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int NWORDS = 10;
  localparam int IDX_W  = 4;
  localparam logic [IDX_W-1:0] LAST_IDX = 4'd9;

  // Maps an emission index to the Din port number (1..10) whose word goes out at that slot.
  // The order undoes the shift-in chain Qout1->Qout6->Qout2->Qout7->...->Qout10, so the
  // first word emitted travels all the way to Qout10 and the last one stays in Qout1.
  function automatic logic [IDX_W-1:0] order_din(input logic [IDX_W-1:0] idx);
    logic [IDX_W-1:0] num;
    case (idx)
      4'd0:    num = 4'd10;
      4'd1:    num = 4'd5;
      4'd2:    num = 4'd9;
      4'd3:    num = 4'd4;
      4'd4:    num = 4'd8;
      4'd5:    num = 4'd3;
      4'd6:    num = 4'd7;
      4'd7:    num = 4'd2;
      4'd8:    num = 4'd6;
      4'd9:    num = 4'd1;
      default: num = 4'd0;
    endcase
    return num;
  endfunction

endpackage

// File: rtl/reg16_ser_sel.sv
// rtl/reg16_ser_sel.sv - combinational 10:1 word mux following the emission order table
module reg16_ser_sel
  import reg16_ser_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [NWORDS-1:0][WIDTH-1:0] words_i,
  input  logic [IDX_W-1:0]             idx_i,
  output logic [WIDTH-1:0]             word_o
);

  logic [IDX_W-1:0] din_num;

  // Pick the captured word whose Din number sits at this index; unreachable indices give zero.
  always_comb begin
    word_o  = '0;
    din_num = order_din(idx_i);
    for (int i = 0; i < NWORDS; i++) begin
      if (din_num == IDX_W'(i + 1)) begin
        word_o = words_i[i];
      end
    end
  end

endmodule

// File: rtl/reg16_ser10.sv
// rtl/reg16_ser10.sv - 10-word parallel-to-serial unloader; `define REG16_SER_LAST_EN adds out_last
module reg16_ser10 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] Din1,
  input  logic [WIDTH-1:0] Din2,
  input  logic [WIDTH-1:0] Din3,
  input  logic [WIDTH-1:0] Din4,
  input  logic [WIDTH-1:0] Din5,
  input  logic [WIDTH-1:0] Din6,
  input  logic [WIDTH-1:0] Din7,
  input  logic [WIDTH-1:0] Din8,
  input  logic [WIDTH-1:0] Din9,
  input  logic [WIDTH-1:0] Din10,
  output logic [WIDTH-1:0] Dout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
`ifdef REG16_SER_LAST_EN
  output logic             out_last,
`endif
  output logic             frame_done
);

  import reg16_ser_pkg::*;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NWORDS-1:0][WIDTH-1:0]  words_q, words_d;
  logic                          frame_done_q, frame_done_d;
  logic [WIDTH-1:0]              sel_word;

  // Next-state, index counter, capture and handshake outputs.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    words_d      = words_q;
    frame_done_d = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          words_d = {Din10, Din9, Din8, Din7, Din6, Din5, Din4, Din3, Din2, Din1};
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (idx_q > LAST_IDX) begin
          // Corrupted index: abandon the frame quietly.
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          out_valid = 1'b1;
          busy      = 1'b1;
          if (out_ready) begin
            if (idx_q == LAST_IDX) begin
              state_d      = IDLE;
              idx_d        = '0;
              frame_done_d = 1'b1;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State register with synchronous reset that overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      words_q      <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      words_q      <= words_d;
      frame_done_q <= frame_done_d;
    end
  end

  reg16_ser_sel #(
    .WIDTH(WIDTH)
  ) u_sel (
    .words_i(words_q),
    .idx_i  (idx_q),
    .word_o (sel_word)
  );

  assign Dout       = out_valid ? sel_word : '0;
  assign frame_done = frame_done_q;

`ifdef REG16_SER_LAST_EN
  assign out_last = out_valid && (idx_q == LAST_IDX);
`endif

endmodule

// File: tb/tb_reg16_ser10.sv
// tb/tb_reg16_ser10.sv - randomized self-checking bench for reg16_ser10 with a shift-chain reference
module tb_reg16_ser10;

  logic        clock;
  logic        reset;
  logic        load;
  logic [15:0] din [1:10];
  logic [15:0] dout;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        frame_done;
`ifdef REG16_SER_LAST_EN
  logic        out_last;
`endif

  int total = 0;
  int bad   = 0;

  reg16_ser10 dut (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .Din1      (din[1]),
    .Din2      (din[2]),
    .Din3      (din[3]),
    .Din4      (din[4]),
    .Din5      (din[5]),
    .Din6      (din[6]),
    .Din7      (din[7]),
    .Din8      (din[8]),
    .Din9      (din[9]),
    .Din10     (din[10]),
    .Dout      (dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
`ifdef REG16_SER_LAST_EN
    .out_last  (out_last),
`endif
    .frame_done(frame_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Shift-in chain of the receiving register: a new word enters chain[0], old ones move along.
  int chain [10] = '{1, 6, 2, 7, 3, 8, 4, 9, 5, 10};

  // Reference model state.
  bit          m_active = 1'b0;
  int          m_idx    = 0;
  bit          m_done   = 1'b0;
  logic [15:0] m_words [1:10];
  logic [15:0] sh      [1:10];
  logic [15:0] basic   [10] = '{16'h000A, 16'h0005, 16'h0009, 16'h0004, 16'h0008,
                                16'h0003, 16'h0007, 16'h0002, 16'h0006, 16'h0001};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // The word at chain position k after ten shifts was emitted at index 9-k.
  function automatic int exp_din(input int idx);
    return chain[9 - idx];
  endfunction

  // Check outputs of the current cycle, apply inputs, advance the model, move to the next cycle.
  task automatic step(input bit rst, input bit ld, input bit rdy);
    logic [15:0] ew;
    ew = m_active ? m_words[exp_din(m_idx)] : 16'h0000;
    chk("out_valid", out_valid, m_active);
    chk("busy", busy, m_active);
    chk("dout", dout, ew);
    chk("frame_done", frame_done, m_done);
`ifdef REG16_SER_LAST_EN
    chk("out_last", out_last, m_active && m_idx == 9);
`endif
    reset     = rst;
    load      = ld;
    out_ready = rdy;
    if (rst) begin
      m_active = 1'b0;
      m_idx    = 0;
      m_done   = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (rdy) begin
          for (int k = 9; k >= 1; k--) sh[chain[k]] = sh[chain[k-1]];
          sh[chain[0]] = dout;
          if (m_idx == 9) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            for (int j = 1; j <= 10; j++) chk("roundtrip", sh[j], m_words[j]);
          end else begin
            m_idx++;
          end
        end
      end else if (ld) begin
        for (int j = 1; j <= 10; j++) m_words[j] = din[j];
        m_active = 1'b1;
        m_idx    = 0;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic rand_din();
    for (int j = 1; j <= 10; j++) din[j] = 16'($urandom);
  endtask

  initial begin
    int n;
    int stall;
    bit rdy;
    reset     = 1'b1;
    load      = 1'b0;
    out_ready = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      din[j] = 16'h0;
      sh[j]  = 16'h0;
      m_words[j] = 16'h0;
    end
    @(posedge clock);
    #1;

    // Reset held a second cycle, then idle.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);

    // Basic frame with Din = 1..10 and a fixed expected order.
    for (int j = 1; j <= 10; j++) din[j] = 16'(j);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("basic_seq", dout, basic[i]);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("basic_done", frame_done, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Round trip with A000..A009.
    for (int j = 1; j <= 10; j++) din[j] = 16'hA000 + 16'(j - 1);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b1);

    // Backpressure: three stalled cycles at index 4.
    for (int j = 1; j <= 10; j++) din[j] = 16'(j);
    step(1'b0, 1'b1, 1'b1);
    n = 0;
    stall = 0;
    while (frame_done !== 1'b1 && n < 30) begin
      rdy = 1'b1;
      if (m_active && m_idx == 4 && stall < 3) begin
        if (stall > 0) chk("bp_hold", dout, 16'h0008);
        rdy = 1'b0;
        stall++;
      end
      step(1'b0, 1'b0, rdy);
      n++;
    end
    chk("bp_cycles", 32'(n), 32'd13);
    step(1'b0, 1'b0, 1'b1);

    // Load while busy at index 2 with fresh Din values.
    rand_din();
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    rand_din();
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1);

    // Reset after six accepts, then a fresh frame.
    rand_din();
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    rand_din();
    step(1'b0, 1'b1, 1'b1);
    chk("restart", dout, din[10]);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      rand_din();
      step($urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7);
    end
    step(1'b0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
